gray_counter_param: RTL and testbench

Parametrised synchronous Gray-code counter, the successor to the fixed 4-bit Gray sequencer. It provides configurable width, up/down counting, a parallel load of a Gray-encoded value, and selectable wrap or saturate behaviour at the ends of the range. A terminal-count pulse is also provided. It is used wherever a single-bit-change count is needed, for example pointers, position encoders and test pattern generation.

---
 rtl/gray_counter_param.sv | 82 ++++++++
 tb/tb_gray_counter_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter: up/down, Gray-encoded parallel load, wrap or saturate, terminal-count pulse.
// Optional registered binary output bin_out when GRAY_BIN_OUT_EN is defined.
module gray_counter_param #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
`ifdef GRAY_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] bin_out
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("gray_counter_param: WIDTH must be 2..32");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] load_bin;
    logic             term;
    logic             tc_nxt;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(load_gray >> i);
        end
    end

    assign term = up ? (&cnt) : (cnt == '0);

    always_comb begin
        cnt_nxt = cnt;
        tc_nxt  = 1'b0;
        if (load) begin
            cnt_nxt = load_bin;
        end else if (en) begin
            if (term) begin
                tc_nxt = 1'b1;
                if (WRAP) begin
                    cnt_nxt = up ? '0 : '1;
                end
            end else begin
                cnt_nxt = up ? (cnt + ONE) : (cnt - ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            gray_out <= '0;
            tc       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            gray_out <= cnt_nxt ^ (cnt_nxt >> 1);
            tc       <= tc_nxt;
        end
    end

`ifdef GRAY_BIN_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out <= '0;
        end else begin
            bin_out <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed and random checks of gray_counter_param at WIDTH 4 and 8, wrap and saturate variants.
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lg = '0;

    logic [3:0] g4w, g4s;
    logic       tc4w, tc4s;
    logic [7:0] g8w, g8s;
    logic       tc8w, tc8s;
`ifdef GRAY_BIN_OUT_EN
    logic [3:0] b4w, b4s;
    logic [7:0] b8w, b8s;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .WRAP(1'b1)) u_4w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg[3:0]),
        .gray_out(g4w), .tc(tc4w)
`ifdef GRAY_BIN_OUT_EN
        , .bin_out(b4w)
`endif
    );
    gray_counter_param #(.WIDTH(4), .WRAP(1'b0)) u_4s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg[3:0]),
        .gray_out(g4s), .tc(tc4s)
`ifdef GRAY_BIN_OUT_EN
        , .bin_out(b4s)
`endif
    );
    gray_counter_param #(.WIDTH(8), .WRAP(1'b1)) u_8w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg),
        .gray_out(g8w), .tc(tc8w)
`ifdef GRAY_BIN_OUT_EN
        , .bin_out(b8w)
`endif
    );
    gray_counter_param #(.WIDTH(8), .WRAP(1'b0)) u_8s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg),
        .gray_out(g8s), .tc(tc8s)
`ifdef GRAY_BIN_OUT_EN
        , .bin_out(b8s)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1; lg = '0;
        step();
        tests++;
        if (g4w !== 4'b0000 || tc4w !== 1'b0 || g8w !== 8'h00 || tc8w !== 1'b0) begin
            fails++;
            $display("FAIL reset_wrap: gray4=%b tc4=%b gray8=%h tc8=%b, want 0", g4w, tc4w, g8w, tc8w);
        end
        tests++;
        if (g4s !== 4'b0000 || tc4s !== 1'b0 || g8s !== 8'h00 || tc8s !== 1'b0) begin
            fails++;
            $display("FAIL reset_sat: gray4=%b tc4=%b gray8=%h tc8=%b, want 0", g4s, tc4s, g8s, tc8s);
        end
`ifdef GRAY_BIN_OUT_EN
        tests++;
        if (b4w !== 4'b0000 || b8s !== 8'h00) begin
            fails++;
            $display("FAIL reset_bin: bin4=%b bin8=%h, want 0", b4w, b8s);
        end
`endif
    endtask

    task automatic test_count_up();
        logic [3:0] seq [0:16];
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                4'b0000};
        rst = 1'b1; step();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            tests++;
            if (g4w !== seq[i] || tc4w !== (i == 16)) begin
                fails++;
                $display("FAIL count_up[%0d]: gray=%b tc=%b, want gray=%b tc=%b", i, g4w, tc4w, seq[i], (i == 16));
            end
            tests++;
            if (g4s !== ((i == 16) ? 4'b1000 : seq[i]) || tc4s !== (i == 16)) begin
                fails++;
                $display("FAIL count_up_sat[%0d]: gray=%b tc=%b, want gray=%b tc=%b",
                         i, g4s, tc4s, (i == 16) ? 4'b1000 : seq[i], (i == 16));
            end
        end
        en = 1'b0;
        step();
        tests++;
        if (g4w !== 4'b0000 || tc4w !== 1'b0) begin
            fails++;
            $display("FAIL hold_after_wrap: gray=%b tc=%b, want 0000 0", g4w, tc4w);
        end
    endtask

    task automatic test_count_down();
        rst = 1'b1; step();
        rst = 1'b0; en = 1'b1; up = 1'b0;
        step();
        tests++;
        if (g4w !== 4'b1000 || tc4w !== 1'b1) begin
            fails++;
            $display("FAIL down_wrap: gray=%b tc=%b, want 1000 1", g4w, tc4w);
        end
        tests++;
        if (g4s !== 4'b0000 || tc4s !== 1'b1) begin
            fails++;
            $display("FAIL down_sat: gray=%b tc=%b, want 0000 1", g4s, tc4s);
        end
        step();
        tests++;
        if (g4w !== 4'b1001 || tc4w !== 1'b0) begin
            fails++;
            $display("FAIL down_step2: gray=%b tc=%b, want 1001 0", g4w, tc4w);
        end
        tests++;
        if (g4s !== 4'b0000 || tc4s !== 1'b1) begin
            fails++;
            $display("FAIL down_sat2: gray=%b tc=%b, want 0000 1", g4s, tc4s);
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; up = 1'b0; lg = 8'h0D;
        step();
        tests++;
        if (g4w !== 4'b1101 || tc4w !== 1'b0) begin
            fails++;
            $display("FAIL load: gray=%b tc=%b, want 1101 0", g4w, tc4w);
        end
`ifdef GRAY_BIN_OUT_EN
        tests++;
        if (b4w !== 4'b1001) begin
            fails++;
            $display("FAIL load_bin: bin=%b, want 1001", b4w);
        end
`endif
        load = 1'b0; up = 1'b1;
        step();
        tests++;
        if (g4w !== 4'b1111 || tc4w !== 1'b0) begin
            fails++;
            $display("FAIL load_then_up: gray=%b tc=%b, want 1111 0", g4w, tc4w);
        end
`ifdef GRAY_BIN_OUT_EN
        tests++;
        if (b4w !== 4'b1010) begin
            fails++;
            $display("FAIL load_then_up_bin: bin=%b, want 1010", b4w);
        end
`endif
        en = 1'b0;
        step();
        tests++;
        if (g4w !== 4'b1111 || tc4w !== 1'b0) begin
            fails++;
            $display("FAIL hold: gray=%b tc=%b, want 1111 0", g4w, tc4w);
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1; step();
        rst = 1'b0; load = 1'b1; en = 1'b0; lg = 8'h08;
        step();
        tests++;
        if (g4s !== 4'b1000 || tc4s !== 1'b0) begin
            fails++;
            $display("FAIL sat_load: gray=%b tc=%b, want 1000 0", g4s, tc4s);
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (g4s !== 4'b1000 || tc4s !== 1'b1) begin
                fails++;
                $display("FAIL sat_hold[%0d]: gray=%b tc=%b, want 1000 1", i, g4s, tc4s);
            end
        end
        up = 1'b0;
        step();
        tests++;
        if (g4s !== 4'b1001 || tc4s !== 1'b0) begin
            fails++;
            $display("FAIL sat_leave: gray=%b tc=%b, want 1001 0", g4s, tc4s);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_priority();
        en = 1'b1; up = 1'b1;
        step(); step();
        rst = 1'b1; load = 1'b1; lg = 8'hA5;
        step();
        tests++;
        if (g4w !== 4'b0000 || tc4w !== 1'b0 || g4s !== 4'b0000 || g8w !== 8'h00 || g8s !== 8'h00) begin
            fails++;
            $display("FAIL reset_priority: g4w=%b tc=%b g4s=%b g8w=%h g8s=%h, want all 0",
                     g4w, tc4w, g4s, g8w, g8s);
        end
`ifdef GRAY_BIN_OUT_EN
        tests++;
        if (b4w !== 4'b0000 || b8w !== 8'h00) begin
            fails++;
            $display("FAIL reset_priority_bin: bin4=%b bin8=%h, want 0", b4w, b8w);
        end
`endif
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic test_random_stress();
        logic [7:0] mw, ms, pw, ps, ew, es;
        logic       tw, ts;
        rst = 1'b1; step();
        rst = 1'b0;
        mw = '0; ms = '0;
        for (int n = 0; n < 2000; n++) begin
            en   = 1'($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 15) == 0);
            lg   = 8'($urandom_range(0, 255));
            tw = 1'b0; ts = 1'b0;
            if (load) begin
                mw = g2b(lg); ms = g2b(lg);
            end else if (en) begin
                if (up) begin
                    if (mw == 8'hFF) begin tw = 1'b1; mw = 8'h00; end else mw = mw + 8'd1;
                    if (ms == 8'hFF) ts = 1'b1; else ms = ms + 8'd1;
                end else begin
                    if (mw == 8'h00) begin tw = 1'b1; mw = 8'hFF; end else mw = mw - 8'd1;
                    if (ms == 8'h00) ts = 1'b1; else ms = ms - 8'd1;
                end
            end
            ew = mw ^ (mw >> 1);
            es = ms ^ (ms >> 1);
            pw = g8w; ps = g8s;
            step();
            tests++;
            if (g8w !== ew || tc8w !== tw) begin
                fails++;
                $display("FAIL rand_wrap[%0d]: gray=%h tc=%b, want gray=%h tc=%b", n, g8w, tc8w, ew, tw);
            end
            tests++;
            if (g8s !== es || tc8s !== ts) begin
                fails++;
                $display("FAIL rand_sat[%0d]: gray=%h tc=%b, want gray=%h tc=%b", n, g8s, tc8s, es, ts);
            end
            if (!load && g8w !== pw) begin
                tests++;
                if ($countones(g8w ^ pw) != 1) begin
                    fails++;
                    $display("FAIL rand_hamming_wrap[%0d]: %h -> %h, want 1 bit change", n, pw, g8w);
                end
            end
            if (!load && g8s !== ps) begin
                tests++;
                if ($countones(g8s ^ ps) != 1) begin
                    fails++;
                    $display("FAIL rand_hamming_sat[%0d]: %h -> %h, want 1 bit change", n, ps, g8s);
                end
            end
`ifdef GRAY_BIN_OUT_EN
            tests++;
            if (b8w !== mw || b8s !== ms) begin
                fails++;
                $display("FAIL rand_bin[%0d]: bin_w=%h bin_s=%h, want %h %h", n, b8w, b8s, mw, ms);
            end
`endif
        end
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_saturate();
        test_reset_priority();
        test_random_stress();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
